sqrt_request_arbiter: RTL and testbench

//  - Shares one iterative square-root unit (datapath + its control path) between NUM_REQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Drives the unit's start/operand; waits for its ready; returns the root tagged with the requester id.
//  - Sits between the requester clients and the square-root top level.

---
 rtl/sqrt_arb_pkg.sv | 20 ++
 rtl/rr_priority_picker.sv | 43 ++++
 rtl/sqrt_request_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sqrt_request_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_arb_pkg.sv
// Package: sqrt_arb_pkg
// Shared definitions for the square-root request arbiter: FSM state codes,
// the state register width, and the requester-id width helper.
package sqrt_arb_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } arb_state_e;

  // Width needed to index n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Module: rr_priority_picker
// Combinational round-robin picker. Searches the valid vector starting at
// index ptr+1 (wrapping after NUM_REQ-1) and returns the first hit.
// Ports:
//   i_valid  in   NUM_REQ  request vector
//   i_ptr    in   ID_W     index of the last requester served
//   o_grant  out  NUM_REQ  one-hot grant (all zero when nothing is valid)
//   o_idx    out  ID_W     index of the granted requester
//   o_any    out  1        at least one request is valid
module rr_priority_picker
  import sqrt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic        w_found;
  int unsigned w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    // k runs 1..NUM_REQ so the last candidate examined is ptr itself.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_valid[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = ID_W'(w_pos);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/sqrt_request_arbiter.sv
// Module: sqrt_request_arbiter
// Shares one iterative square-root unit between NUM_REQ requesters with
// round-robin arbitration and a single operation in flight.
// Flow: IDLE (grant + latch operand/id) -> LAUNCH (start pulse) -> WAIT
// (until unit ready) -> RESP (result pulse) -> IDLE.
// Optional feature macro: SQRT_ARB_TIMEOUT_EN adds a WAIT watchdog of
// TMO_CYC cycles and the timeout_o port.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid_i     per-requester request
//   req_data_i      per-requester operand, slot k = [k*DATA_W +: DATA_W]
//   req_ready_o     one-hot accept pulse (combinational, IDLE only)
//   resp_valid_o    one-cycle result pulse
//   resp_id_o       requester index of the result (held after RESP)
//   resp_root_o     result root (held after RESP)
//   sqrt_start_o    one-cycle start pulse to the unit
//   sqrt_operand_o  operand to the unit, stable LAUNCH through WAIT
//   sqrt_ready_i    unit ready/done flag
//   sqrt_root_i     unit root output
//   busy_o          high in any state except IDLE
//   timeout_o       watchdog abort pulse (SQRT_ARB_TIMEOUT_EN only)
module sqrt_request_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROOT_W  = (DATA_W + 1) / 2,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        resp_valid_o,
  output logic [id_width(NUM_REQ)-1:0] resp_id_o,
  output logic [ROOT_W-1:0]           resp_root_o,
  output logic                        sqrt_start_o,
  output logic [DATA_W-1:0]           sqrt_operand_o,
  input  logic                        sqrt_ready_i,
  input  logic [ROOT_W-1:0]           sqrt_root_i,
`ifdef SQRT_ARB_TIMEOUT_EN
  output logic                        busy_o,
  output logic                        timeout_o
`else
  output logic                        busy_o
`endif
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  arb_state_e          r_state, w_state_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_operand;
  logic [ID_W-1:0]     r_resp_id;
  logic [ROOT_W-1:0]   r_resp_root;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gidx;
  logic                w_any;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_accept;
  logic                w_capture;
  logic                w_tmo_fire;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_valid (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Operand mux driven by the one-hot grant; only the winner's slot is used.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
  logic [TmoW-1:0] r_tmo_cnt;

  // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StWait) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign timeout_o = w_tmo_fire;
`endif

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = '0;
    sqrt_start_o = 1'b0;
    resp_valid_o = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_tmo_fire   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Reset gating keeps the combinational accept quiet while rst is high.
        if (w_any && !rst) begin
          w_accept     = 1'b1;
          req_ready_o  = w_grant;
          w_state_next = StLaunch;
        end
      end
      StLaunch: begin
        // Unit ready is deliberately not looked at here: it may still be
        // high from the previous operation.
        sqrt_start_o = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        if (sqrt_ready_i) begin
          w_capture    = 1'b1;
          w_state_next = StResp;
        end
`ifdef SQRT_ARB_TIMEOUT_EN
        else if (r_tmo_cnt == TmoW'(TMO_CYC - 1)) begin
          w_tmo_fire   = 1'b1;
          w_state_next = StIdle;
        end
`endif
      end
      StResp: begin
        resp_valid_o = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_operand   <= '0;
      r_resp_id   <= '0;
      r_resp_root <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_id      <= w_gidx;
        r_operand <= w_sel_data;
      end
      if (w_capture) begin
        r_resp_id   <= r_id;
        r_resp_root <= sqrt_root_i;
      end
      if ((r_state == StResp) || w_tmo_fire) begin
        r_ptr <= r_id;
      end
    end
  end

  assign busy_o         = (r_state != StIdle);
  assign sqrt_operand_o = r_operand;
  assign resp_id_o      = r_resp_id;
  assign resp_root_o    = r_resp_root;

endmodule

// File: tb/tb_sqrt_request_arbiter.sv
// Testbench for sqrt_request_arbiter (NUM_REQ=4, DATA_W=8, ROOT_W=4).
// A behavioural square-root unit raises ready a programmable number of
// cycles after each start pulse.
module tb_sqrt_request_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        resp_valid_o;
  logic [1:0]  resp_id_o;
  logic [3:0]  resp_root_o;
  logic        sqrt_start_o;
  logic [7:0]  sqrt_operand_o;
  logic        sqrt_ready_i;
  logic [3:0]  sqrt_root_i;
  logic        busy_o;
`ifdef SQRT_ARB_TIMEOUT_EN
  logic        timeout_o;
`endif

  int checks = 0;
  int errors = 0;

  // Unit model controls
  int       unit_delay = 5;
  bit       unit_hang = 1'b0;
  bit       hold_ready_launch = 1'b0;
  bit       preset_ready = 1'b0;
  int       m_cnt = 0;
  logic [7:0] m_op = '0;

  always #5 clk = ~clk;

`ifdef SQRT_ARB_TIMEOUT_EN
  sqrt_request_arbiter #(
    .NUM_REQ (4), .DATA_W (8), .ROOT_W (4), .TMO_CYC (8)
  ) dut (
    .clk (clk), .rst (rst), .req_valid_i (req_valid_i), .req_data_i (req_data_i),
    .req_ready_o (req_ready_o), .resp_valid_o (resp_valid_o), .resp_id_o (resp_id_o),
    .resp_root_o (resp_root_o), .sqrt_start_o (sqrt_start_o),
    .sqrt_operand_o (sqrt_operand_o), .sqrt_ready_i (sqrt_ready_i),
    .sqrt_root_i (sqrt_root_i), .busy_o (busy_o), .timeout_o (timeout_o)
  );
`else
  sqrt_request_arbiter #(
    .NUM_REQ (4), .DATA_W (8), .ROOT_W (4), .TMO_CYC (64)
  ) dut (
    .clk (clk), .rst (rst), .req_valid_i (req_valid_i), .req_data_i (req_data_i),
    .req_ready_o (req_ready_o), .resp_valid_o (resp_valid_o), .resp_id_o (resp_id_o),
    .resp_root_o (resp_root_o), .sqrt_start_o (sqrt_start_o),
    .sqrt_operand_o (sqrt_operand_o), .sqrt_ready_i (sqrt_ready_i),
    .sqrt_root_i (sqrt_root_i), .busy_o (busy_o)
  );
`endif

  function automatic logic [3:0] isqrt(input logic [7:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return 4'(r);
  endfunction

  // Square-root unit model; acts 1ns after each rising edge.
  initial begin
    sqrt_ready_i = 1'b0;
    sqrt_root_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_cnt = 0;
        sqrt_ready_i = 1'b0;
      end else if (preset_ready) begin
        preset_ready = 1'b0;
        sqrt_ready_i = 1'b1;
      end else if (sqrt_start_o) begin
        m_op  = sqrt_operand_o;
        m_cnt = unit_delay;
        if (!hold_ready_launch) sqrt_ready_i = 1'b0;
      end else if (m_cnt > 0) begin
        sqrt_ready_i = 1'b0;
        m_cnt--;
        if (m_cnt == 0 && !unit_hang) begin
          sqrt_ready_i = 1'b1;
          sqrt_root_i  = isqrt(m_op);
        end
      end
    end
  end

  // Steps negedges until req_ready_o is nonzero; cyc = 40 means it never came.
  task automatic wait_grant(output int cyc);
    cyc = 0;
    #1;
    while (req_ready_o == 4'b0 && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  // Steps negedges until resp_valid_o; counts extra start pulses seen.
  task automatic run_to_resp(output int cyc, output int starts);
    cyc = 0;
    starts = 0;
    while (!resp_valid_o && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
      if (sqrt_start_o) starts++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_i = 4'b0001;
    req_data_i = 32'h0000_0031;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready_o !== 4'b0 || busy_o !== 1'b0 || sqrt_start_o !== 1'b0 ||
        resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b start=%b rvalid=%b, want all 0",
               req_ready_o, busy_o, sqrt_start_o, resp_valid_o);
    end
    checks++;
    if (sqrt_operand_o !== 8'd0 || resp_id_o !== 2'd0 || resp_root_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: op=%0d id=%0d root=%0d, want 0 0 0",
               sqrt_operand_o, resp_id_o, resp_root_o);
    end
    @(negedge clk);
    req_valid_i = 4'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int c, s;
    @(negedge clk);
    req_valid_i = 4'b0001;
    req_data_i[7:0] = 8'd49;
    wait_grant(c);
    checks++;
    if (c !== 0 || req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL single_accept: ready=%b after %0d cycles, want 0001 at once",
               req_ready_o, c);
    end
    @(negedge clk);
    req_valid_i = 4'b0;
    #1;
    checks++;
    if (sqrt_start_o !== 1'b1 || sqrt_operand_o !== 8'd49 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_launch: start=%b op=%0d busy=%b, want 1 49 1",
               sqrt_start_o, sqrt_operand_o, busy_o);
    end
    run_to_resp(c, s);
    checks++;
    if (c !== 6 || s !== 0) begin
      errors++;
      $display("FAIL single_latency: cycles=%0d extra_starts=%0d, want 6 0", c, s);
    end
    checks++;
    if (resp_id_o !== 2'd0 || resp_root_o !== 4'd7) begin
      errors++;
      $display("FAIL single_resp: id=%0d root=%0d, want 0 7", resp_id_o, resp_root_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || resp_root_o !== 4'd7 ||
        resp_id_o !== 2'd0) begin
      errors++;
      $display("FAIL single_after: rvalid=%b busy=%b id=%0d root=%0d, want 0 0 0 7",
               resp_valid_o, busy_o, resp_id_o, resp_root_o);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ops [4];
    logic [3:0] roots [4];
    int c, s, g;
    ops[0] = 8'd0; ops[1] = 8'd1; ops[2] = 8'd4; ops[3] = 8'd9;
    roots[0] = 4'd0; roots[1] = 4'd1; roots[2] = 4'd2; roots[3] = 4'd3;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_data_i = {8'd9, 8'd4, 8'd1, 8'd0};
    req_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = i % 4;
      wait_grant(c);
      checks++;
      if (req_ready_o !== 4'(1 << g) || c !== ((i == 0) ? 0 : 1)) begin
        errors++;
        $display("FAIL rr_grant%0d: ready=%b after %0d cycles, want %b after %0d",
                 i, req_ready_o, c, 4'(1 << g), (i == 0) ? 0 : 1);
      end
      @(negedge clk);
      #1;
      checks++;
      if (sqrt_operand_o !== ops[g]) begin
        errors++;
        $display("FAIL rr_operand%0d: op=%0d, want %0d", i, sqrt_operand_o, ops[g]);
      end
      run_to_resp(c, s);
      checks++;
      if (resp_id_o !== 2'(g) || resp_root_o !== roots[g] || req_ready_o !== 4'b0 ||
          c >= 40) begin
        errors++;
        $display("FAIL rr_resp%0d: id=%0d root=%0d ready=%b cyc=%0d, want %0d %0d 0000",
                 i, resp_id_o, resp_root_o, req_ready_o, c, g, roots[g]);
      end
    end
    req_valid_i = 4'b0;
  endtask

  task automatic test_wait_arrival();
    int c, s, bad, n;
    @(negedge clk);
    req_valid_i = 4'b0010;
    req_data_i[15:8] = 8'd25;
    wait_grant(c);
    checks++;
    if (req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL arr_grant1: ready=%b, want 0010", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 4'b0100;
    req_data_i[23:16] = 8'd64;
    bad = 0; s = 0; n = 0;
    while (!resp_valid_o && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (req_ready_o !== 4'b0) bad++;
      if (sqrt_start_o) s++;
    end
    checks++;
    if (bad !== 0 || s !== 0 || n >= 40) begin
      errors++;
      $display("FAIL arr_busy: early_ready=%0d extra_starts=%0d cyc=%0d, want 0 0 <40",
               bad, s, n);
    end
    checks++;
    if (resp_id_o !== 2'd1 || resp_root_o !== 4'd5) begin
      errors++;
      $display("FAIL arr_resp1: id=%0d root=%0d, want 1 5", resp_id_o, resp_root_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL arr_grant2: ready=%b one cycle after RESP, want 0100", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 4'b0;
    run_to_resp(c, s);
    checks++;
    if (resp_id_o !== 2'd2 || resp_root_o !== 4'd8 || s !== 0) begin
      errors++;
      $display("FAIL arr_resp2: id=%0d root=%0d starts=%0d, want 2 8 0",
               resp_id_o, resp_root_o, s);
    end
  endtask

  task automatic test_reset_mid();
    int c, s;
    @(negedge clk);
    req_valid_i = 4'b0010;
    req_data_i[15:8] = 8'd16;
    wait_grant(c);
    @(negedge clk);
    req_valid_i = 4'b0;
    repeat (2) @(negedge clk);
    req_data_i[7:0] = 8'd36;
    req_data_i[31:24] = 8'd81;
    req_valid_i = 4'b1001;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || sqrt_start_o !== 1'b0 || resp_valid_o !== 1'b0 ||
        req_ready_o !== 4'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: busy=%b start=%b rvalid=%b ready=%b, want all 0",
               busy_o, sqrt_start_o, resp_valid_o, req_ready_o);
    end
    checks++;
    if (sqrt_operand_o !== 8'd0 || resp_id_o !== 2'd0 || resp_root_o !== 4'd0) begin
      errors++;
      $display("FAIL midrst_data: op=%0d id=%0d root=%0d, want 0 0 0",
               sqrt_operand_o, resp_id_o, resp_root_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_grant(c);
    checks++;
    if (req_ready_o !== 4'b0001 || c !== 0) begin
      errors++;
      $display("FAIL midrst_grant: ready=%b after %0d cycles, want 0001 at once",
               req_ready_o, c);
    end
    @(negedge clk);
    req_valid_i = 4'b0;
    run_to_resp(c, s);
    checks++;
    if (resp_id_o !== 2'd0 || resp_root_o !== 4'd6 || c >= 40) begin
      errors++;
      $display("FAIL midrst_resp: id=%0d root=%0d cyc=%0d, want 0 6", resp_id_o,
               resp_root_o, c);
    end
  endtask

  task automatic test_ready_launch();
    int c, s;
    @(negedge clk);
    preset_ready = 1'b1;
    hold_ready_launch = 1'b1;
    @(negedge clk);
    req_valid_i = 4'b0010;
    req_data_i[15:8] = 8'd100;
    wait_grant(c);
    checks++;
    if (req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL rdylaunch_grant: ready=%b, want 0010", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 4'b0;
    #1;
    checks++;
    if (sqrt_start_o !== 1'b1) begin
      errors++;
      $display("FAIL rdylaunch_start: start=%b, want 1", sqrt_start_o);
    end
    @(negedge clk);
    hold_ready_launch = 1'b0;
    #1;
    checks++;
    if (resp_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rdylaunch_ignored: rvalid=%b busy=%b, want 0 1", resp_valid_o, busy_o);
    end
    run_to_resp(c, s);
    checks++;
    if (c !== 5 || resp_id_o !== 2'd1 || resp_root_o !== 4'd10) begin
      errors++;
      $display("FAIL rdylaunch_resp: cyc=%0d id=%0d root=%0d, want 5 1 10", c,
               resp_id_o, resp_root_o);
    end
  endtask

`ifdef SQRT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c, s, n, rv;
    @(negedge clk);
    unit_hang = 1'b1;
    req_data_i[23:16] = 8'd200;
    req_data_i[31:24] = 8'd144;
    req_valid_i = 4'b1100;
    wait_grant(c);
    checks++;
    if (req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL tmo_grant: ready=%b, want 0100", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 4'b1000;
    n = 0; rv = 0;
    while (!timeout_o && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (resp_valid_o) rv++;
    end
    checks++;
    if (n !== 8 || rv !== 0) begin
      errors++;
      $display("FAIL tmo_pulse: after %0d wait cycles, resp_pulses=%0d, want 8 0", n, rv);
    end
    unit_hang = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready_o !== 4'b1000 || timeout_o !== 1'b0 || resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_next: ready=%b tmo=%b rvalid=%b, want 1000 0 0", req_ready_o,
               timeout_o, resp_valid_o);
    end
    @(negedge clk);
    req_valid_i = 4'b0;
    run_to_resp(c, s);
    checks++;
    if (resp_id_o !== 2'd3 || resp_root_o !== 4'd12) begin
      errors++;
      $display("FAIL tmo_resp: id=%0d root=%0d, want 3 12", resp_id_o, resp_root_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid_i = 4'b0;
    req_data_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wait_arrival();
    test_reset_mid();
    test_ready_launch();
`ifdef SQRT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
